calorie_topk: RTL and testbench
===============================

# calorie_topk

Streaming top-K group-sum tracker for the day-1 puzzle datapath; it replaces the single-maximum, whole-array-in solution with a cycle-accurate handshake core. Unsigned values arrive one per beat, grouped by separator beats. The block accumulates each group's sum, keeps the K largest sums in a sorted register array, and reports both the largest sum and the total of the top K. It sits between the file-reader front end and the result checker.

## Interface
- DATA_W, 32: width of one input value.
- SUM_W, 40: width of the group accumulator and of each top-K slot.
- K, 3: number of largest group sums retained (K >= 1).
- TOT_W, SUM_W + $clog2(K+1): width of the top-K total; derived, not overridden.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart; zeroes all state and returns to ACCUM.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  value; ignored when in_sep=1.
- in_sep  in  1  beat is a group separator (blank line); carries no data.
- in_last  in  1  final beat of the stream; closes the current group.
- done  out  1  result valid; held high until clear or reset.
- max_sum  out  SUM_W  largest group sum (slot 0).
- top_sum  out  TOT_W  sum of all K slots.
- group_count  out  16  number of non-empty groups closed; saturates at 0xFFFF.

## Operation
- States: ACCUM, INSERT, DONE. Reset and clear both lead to ACCUM.
- ACCUM:
  - in_ready=1.
  - Data beat (in_sep=0): acc <= sat(acc + in_data); set the nonempty flag.
  - Closing beat (in_sep=1, or in_last=1): latch acc, nonempty and last into a pending register, clear acc and nonempty, go to INSERT.
  - in_last=1 with in_sep=0 first adds in_data to the sum being closed.
- INSERT (exactly 1 cycle):
  - in_ready=0.
  - If the pending group is non-empty, insert it into slots top[0..K-1], which are kept in descending order. The insert position is the first index i with pending > top[i]. Entries at i..K-2 shift down one slot; top[K-1] is dropped. A value equal to an existing entry lands after it (strict compare).
  - If the pending group is non-empty, group_count increments.
  - An empty group (consecutive separators, or a separator right after the previous close) is discarded: no insert, no count.
  - Next state is DONE if pending last is set, else ACCUM.
- DONE:
  - in_ready=0.
  - done=1; max_sum and top_sum hold their values.
  - Only clear or reset leave DONE.
- Arithmetic:
  - Accumulator saturates at 2^SUM_W-1 and does not wrap.
  - top_sum is a full-width sum of K slots; TOT_W guarantees it cannot overflow.
- Empty slots hold 0. With fewer than K groups, top_sum is the sum of the groups present.
- Reset values: in_ready=1 (after reset deasserts), done=0, max_sum=0, top_sum=0, group_count=0, acc=0, all slots=0, state=ACCUM.
- clear:
  - Overrides any in-flight beat. A beat offered in the clear cycle is not accepted, and in_ready=0 in that cycle.
  - Results are the same as reset, one cycle later.
- rst_n asserted mid-stream (any state) immediately returns all outputs to their reset values. Partial sums are lost.

## Timing
- Data beats: 1 per cycle sustained inside a group.
- Each closing beat costs 1 bubble cycle (INSERT, in_ready=0).
- Last beat accepted at edge t:
  - INSERT during cycle t..t+1.
  - At edge t+1, slots, group_count, max_sum and top_sum update together and the state moves to DONE.
  - done=1 is visible in the cycle after edge t+1.
- top_sum and max_sum are registered, loaded from post-insertion slot values. They also update after every INSERT, but are only guaranteed final when done=1.
- in_valid may be held high across INSERT; the beat waits and is accepted on the first ACCUM cycle.
- in_sep=1 with in_last=1 is a single closing beat; the group is closed once.

## Test plan
- Puzzle example, K=3 (1000,2000,3000 | 4000 | 5000,6000 | 7000,8000,9000 | 10000 last): max_sum=24000, top_sum=45000, group_count=5, done 2 cycles after the last beat.
- Same stream with K=1: max_sum=top_sum=24000. With K=8: top_sum=55000, slots 5..7 = 0.
- Ties and empty groups: 500 | sep | sep | 500 | 300 last, K=2. Required: group_count=3, top_sum=1000; the duplicate 500 lands in slot 1 and 300 is dropped.
- Saturation, SUM_W=8, DATA_W=8: 200,100 last gives max_sum=255, with no wrap.
- Backpressure: in_valid held high continuously. in_ready must drop for exactly one cycle after each separator, and no beat is lost or duplicated. Result matches the puzzle example.
- rst_n pulsed low mid-group, then clear pulsed in DONE. Outputs go to 0 immediately on reset and after the clear edge. A fresh stream of 7 last must then give max_sum=top_sum=7 and group_count=1.

Source files
------------

// File: rtl/calorie_topk.sv
// Streaming group-sum tracker: accumulates separator-delimited groups and
// keeps the K largest sums in a descending register array.
module calorie_topk #(
  parameter  int DATA_W = 32,
  parameter  int SUM_W  = 40,
  parameter  int K      = 3,
  localparam int TOT_W  = SUM_W + $clog2(K + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sep,
  input  logic              in_last,
  output logic              done,
  output logic [SUM_W-1:0]  max_sum,
  output logic [TOT_W-1:0]  top_sum,
  output logic [15:0]       group_count
);

  localparam logic [1:0] S_ACCUM  = 2'd0;
  localparam logic [1:0] S_INSERT = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       r_state;
  logic [SUM_W-1:0] r_acc;
  logic             r_ne;
  logic [SUM_W-1:0] r_pend;
  logic             r_pend_ne;
  logic             r_pend_last;
  logic [SUM_W-1:0] r_top [K];
  logic [SUM_W-1:0] r_max;
  logic [TOT_W-1:0] r_tot;
  logic [15:0]      r_cnt;

  logic             w_accept;
  logic             w_close;
  logic [SUM_W:0]   w_wide;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_new [K];
  logic [TOT_W-1:0] w_tot;

  assign in_ready = (r_state == S_ACCUM) && !clear;
  assign w_accept = in_valid && in_ready;
  assign w_close  = in_sep || in_last;

  // One extra bit catches the carry that triggers saturation.
  assign w_wide = {1'b0, r_acc} + (SUM_W + 1)'(in_data);
  assign w_sum  = w_wide[SUM_W] ? {SUM_W{1'b1}} : w_wide[SUM_W-1:0];

  // Slots are descending, so the strict compare is monotonic over i:
  // the first slot that loses takes the pending sum, the rest shift down.
  always_comb begin
    logic             gt;
    logic             prev_gt;
    logic [SUM_W-1:0] up;
    prev_gt = 1'b0;
    up      = '0;
    w_tot   = '0;
    for (int i = 0; i < K; i++) begin
      gt = r_pend > r_top[i];
      if (!gt)
        w_new[i] = r_top[i];
      else if (prev_gt)
        w_new[i] = up;
      else
        w_new[i] = r_pend;
      prev_gt = gt;
      up      = r_top[i];
      w_tot   = w_tot + TOT_W'(w_new[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_ne        <= 1'b0;
      r_pend      <= '0;
      r_pend_ne   <= 1'b0;
      r_pend_last <= 1'b0;
      r_max       <= '0;
      r_tot       <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < K; i++)
        r_top[i] <= '0;
    end else if (clear) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_ne        <= 1'b0;
      r_pend      <= '0;
      r_pend_ne   <= 1'b0;
      r_pend_last <= 1'b0;
      r_max       <= '0;
      r_tot       <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < K; i++)
        r_top[i] <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            if (w_close) begin
              r_pend      <= in_sep ? r_acc : w_sum;
              r_pend_ne   <= r_ne || !in_sep;
              r_pend_last <= in_last;
              r_acc       <= '0;
              r_ne        <= 1'b0;
              r_state     <= S_INSERT;
            end else begin
              r_acc <= w_sum;
              r_ne  <= 1'b1;
            end
          end
        end
        S_INSERT: begin
          if (r_pend_ne) begin
            for (int i = 0; i < K; i++)
              r_top[i] <= w_new[i];
            r_max <= w_new[0];
            r_tot <= w_tot;
            if (r_cnt != 16'hFFFF)
              r_cnt <= r_cnt + 16'd1;
          end
          r_state <= r_pend_last ? S_DONE : S_ACCUM;
        end
        S_DONE: r_state <= S_DONE;
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign done        = (r_state == S_DONE);
  assign max_sum     = r_max;
  assign top_sum     = r_tot;
  assign group_count = r_cnt;

endmodule

// File: tb/tb_calorie_topk.sv
// Bench for calorie_topk: five parameterisations share one stimulus bus
// and are compared against a sort-based reference model.
module tb_calorie_topk;

  typedef struct packed {
    logic [31:0] d;
    logic        sep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sep = 1'b0;
  logic        in_last = 1'b0;

  logic [4:0]  w_rdy;
  logic [4:0]  w_done;
  logic [15:0] w_cnt [5];
  logic [39:0] m0, m1, m2, m3;
  logic [7:0]  m4;
  logic [41:0] t0;
  logic [40:0] t1;
  logic [43:0] t2;
  logic [41:0] t3;
  logic [9:0]  t4;

  longint unsigned act_max [5];
  longint unsigned act_top [5];
  longint unsigned exp_max [5];
  longint unsigned exp_top [5];
  longint unsigned exp_cnt [5];

  int KK [5] = '{3, 1, 8, 2, 3};
  int SW [5] = '{40, 40, 40, 40, 8};

  beat_t      stream [$];
  bit         rq_exp [$];
  logic [4:0] rq_obs [$];
  int         timeouts;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  calorie_topk #(.K(3)) u_k3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(w_rdy[0]), .in_data(in_data), .in_sep(in_sep),
    .in_last(in_last), .done(w_done[0]), .max_sum(m0),
    .top_sum(t0), .group_count(w_cnt[0]));

  calorie_topk #(.K(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(w_rdy[1]), .in_data(in_data), .in_sep(in_sep),
    .in_last(in_last), .done(w_done[1]), .max_sum(m1),
    .top_sum(t1), .group_count(w_cnt[1]));

  calorie_topk #(.K(8)) u_k8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(w_rdy[2]), .in_data(in_data), .in_sep(in_sep),
    .in_last(in_last), .done(w_done[2]), .max_sum(m2),
    .top_sum(t2), .group_count(w_cnt[2]));

  calorie_topk #(.K(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(w_rdy[3]), .in_data(in_data), .in_sep(in_sep),
    .in_last(in_last), .done(w_done[3]), .max_sum(m3),
    .top_sum(t3), .group_count(w_cnt[3]));

  calorie_topk #(.DATA_W(8), .SUM_W(8), .K(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(w_rdy[4]), .in_data(in_data[7:0]), .in_sep(in_sep),
    .in_last(in_last), .done(w_done[4]), .max_sum(m4),
    .top_sum(t4), .group_count(w_cnt[4]));

  always_comb begin
    act_max[0] = 64'(m0); act_top[0] = 64'(t0);
    act_max[1] = 64'(m1); act_top[1] = 64'(t1);
    act_max[2] = 64'(m2); act_top[2] = 64'(t2);
    act_max[3] = 64'(m3); act_top[3] = 64'(t3);
    act_max[4] = 64'(m4); act_top[4] = 64'(t4);
  end

  task automatic push(input logic [31:0] d, input bit s, input bit l);
    stream.push_back('{d: d, sep: s, last: l});
  endtask

  task automatic build_puzzle();
    stream.delete();
    push(1000, 0, 0); push(2000, 0, 0); push(3000, 0, 0); push(0, 1, 0);
    push(4000, 0, 0); push(0, 1, 0);
    push(5000, 0, 0); push(6000, 0, 0); push(0, 1, 0);
    push(7000, 0, 0); push(8000, 0, 0); push(9000, 0, 0); push(0, 1, 0);
    push(10000, 0, 1);
  endtask

  // Reference: collect closed non-empty group sums, sort, take the K largest.
  task automatic model();
    longint unsigned sums [$];
    longint unsigned acc, mx, dm;
    bit ne;
    for (int j = 0; j < 5; j++) begin
      sums.delete();
      mx  = (64'd1 << SW[j]) - 64'd1;
      dm  = (j == 4) ? 64'hFF : 64'hFFFF_FFFF;
      acc = 0;
      ne  = 0;
      foreach (stream[b]) begin
        if (!stream[b].sep) begin
          acc = acc + (64'(stream[b].d) & dm);
          if (acc > mx) acc = mx;
          ne = 1;
        end
        if (stream[b].sep || stream[b].last) begin
          if (ne) sums.push_back(acc);
          acc = 0;
          ne  = 0;
        end
        if (stream[b].last) break;
      end
      sums.rsort();
      exp_max[j] = (sums.size() > 0) ? sums[0] : 64'd0;
      exp_top[j] = 0;
      for (int i = 0; i < KK[j] && i < sums.size(); i++)
        exp_top[j] = exp_top[j] + sums[i];
      exp_cnt[j] = (sums.size() > 65535) ? 64'd65535 : 64'(sums.size());
    end
  endtask

  // Offers each beat until accepted; ready is expected low only in the
  // cycle right after a closing beat was taken.
  task automatic drive(input bit gaps);
    bit ins, acc;
    int guard;
    ins = 0;
    timeouts = 0;
    rq_exp.delete();
    rq_obs.delete();
    foreach (stream[i]) begin
      guard = 0;
      acc = 0;
      while (!acc && guard < 60) begin
        @(negedge clk);
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = stream[i].d;
        in_sep   = stream[i].sep;
        in_last  = stream[i].last;
        #1;
        rq_exp.push_back(!ins);
        rq_obs.push_back(w_rdy);
        acc = in_valid && !ins;
        ins = acc && (stream[i].sep || stream[i].last);
        guard++;
      end
      if (!acc) timeouts++;
    end
    @(negedge clk);
    in_valid = 0;
    in_sep   = 0;
    in_last  = 0;
    in_data  = '0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w_done[j] !== 1'b0 || act_max[j] !== 0 || act_top[j] !== 0 || w_cnt[j] !== 16'd0) begin
        errors++;
        $display("FAIL reset dut%0d done=%0b max=%0d top=%0d cnt=%0d exp all 0",
                 j, w_done[j], act_max[j], act_top[j], w_cnt[j]);
      end
    end
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (w_rdy !== 5'b11111) begin
      errors++;
      $display("FAIL reset_ready got %b exp 11111", w_rdy);
    end
  endtask

  task automatic test_puzzle();
    build_puzzle();
    model();
    drive(1);
    #1;
    checks++;
    if (w_done !== 5'b0 || timeouts != 0) begin
      errors++;
      $display("FAIL puzzle_insert done=%b timeouts=%0d exp 0", w_done, timeouts);
    end
    @(negedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w_done[j] !== 1'b1) begin
        errors++; $display("FAIL puzzle_done dut%0d got %0b exp 1", j, w_done[j]);
      end
      checks++;
      if (act_max[j] !== exp_max[j]) begin
        errors++; $display("FAIL puzzle_max dut%0d got %0d exp %0d", j, act_max[j], exp_max[j]);
      end
      checks++;
      if (act_top[j] !== exp_top[j]) begin
        errors++; $display("FAIL puzzle_top dut%0d got %0d exp %0d", j, act_top[j], exp_top[j]);
      end
      checks++;
      if (64'(w_cnt[j]) !== exp_cnt[j]) begin
        errors++; $display("FAIL puzzle_cnt dut%0d got %0d exp %0d", j, w_cnt[j], exp_cnt[j]);
      end
    end
    checks++;
    if (m0 !== 40'd24000 || t0 !== 42'd45000 || w_cnt[0] !== 16'd5) begin
      errors++; $display("FAIL puzzle_k3 max=%0d top=%0d cnt=%0d exp 24000 45000 5", m0, t0, w_cnt[0]);
    end
    checks++;
    if (m1 !== 40'd24000 || t1 !== 41'd24000) begin
      errors++; $display("FAIL puzzle_k1 max=%0d top=%0d exp 24000 24000", m1, t1);
    end
    checks++;
    if (t2 !== 44'd55000) begin
      errors++; $display("FAIL puzzle_k8 top=%0d exp 55000", t2);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (w_done !== 5'b11111 || m0 !== 40'd24000 || w_rdy !== 5'b0) begin
      errors++; $display("FAIL puzzle_hold done=%b max=%0d rdy=%b exp 11111 24000 00000", w_done, m0, w_rdy);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    build_puzzle();
    model();
    drive(0);
    foreach (rq_exp[i]) begin
      checks++;
      if (rq_obs[i] !== {5{rq_exp[i]}}) begin
        errors++; $display("FAIL b2b_ready cycle%0d got %b exp %b", i, rq_obs[i], {5{rq_exp[i]}});
      end
    end
    checks++;
    if (rq_exp.size() != stream.size() + 4) begin
      errors++; $display("FAIL b2b_cycles got %0d exp %0d", rq_exp.size(), stream.size() + 4);
    end
    @(negedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w_done[j] !== 1'b1 || act_max[j] !== exp_max[j] || act_top[j] !== exp_top[j] || 64'(w_cnt[j]) !== exp_cnt[j]) begin
        errors++;
        $display("FAIL b2b_result dut%0d done=%0b max=%0d top=%0d cnt=%0d exp 1 %0d %0d %0d",
                 j, w_done[j], act_max[j], act_top[j], w_cnt[j], exp_max[j], exp_top[j], exp_cnt[j]);
      end
    end
    do_clear();
  endtask

  task automatic test_ties();
    stream.delete();
    push(500, 0, 0); push(0, 1, 0); push(0, 1, 0);
    push(500, 0, 0); push(0, 1, 0); push(300, 0, 1);
    model();
    drive(1);
    @(negedge clk);
    #1;
    checks++;
    if (t3 !== 42'd1000 || w_cnt[3] !== 16'd3 || m3 !== 40'd500) begin
      errors++; $display("FAIL ties_k2 top=%0d cnt=%0d max=%0d exp 1000 3 500", t3, w_cnt[3], m3);
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w_done[j] !== 1'b1 || act_max[j] !== exp_max[j] || act_top[j] !== exp_top[j] || 64'(w_cnt[j]) !== exp_cnt[j]) begin
        errors++;
        $display("FAIL ties_result dut%0d done=%0b max=%0d top=%0d cnt=%0d exp 1 %0d %0d %0d",
                 j, w_done[j], act_max[j], act_top[j], w_cnt[j], exp_max[j], exp_top[j], exp_cnt[j]);
      end
    end
    do_clear();
  endtask

  task automatic test_saturation();
    stream.delete();
    push(200, 0, 0); push(100, 0, 1);
    model();
    drive(0);
    @(negedge clk);
    #1;
    checks++;
    if (m4 !== 8'd255 || t4 !== 10'd255) begin
      errors++; $display("FAIL sat_8bit max=%0d top=%0d exp 255 255", m4, t4);
    end
    checks++;
    if (m0 !== 40'd300) begin
      errors++; $display("FAIL sat_wide max=%0d exp 300", m0);
    end
    do_clear();
  endtask

  task automatic test_random();
    int ng, nb;
    for (int it = 0; it < 25; it++) begin
      stream.delete();
      ng = $urandom_range(1, 7);
      for (int g = 0; g < ng; g++) begin
        if ($urandom_range(0, 4) == 0) push(0, 1, 0);
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++)
          push(($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 60000)), 0, 0);
        if (g < ng - 1) push(0, 1, 0);
      end
      if ($urandom_range(0, 1) == 1)
        push(32'($urandom_range(0, 60000)), 0, 1);
      else
        push(0, 1, 1);
      model();
      drive($urandom_range(0, 1) == 1);
      @(negedge clk);
      #1;
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (w_done[j] !== 1'b1 || act_max[j] !== exp_max[j] || act_top[j] !== exp_top[j] || 64'(w_cnt[j]) !== exp_cnt[j]) begin
          errors++;
          $display("FAIL rand%0d dut%0d done=%0b max=%0d top=%0d cnt=%0d exp 1 %0d %0d %0d",
                   it, j, w_done[j], act_max[j], act_top[j], w_cnt[j], exp_max[j], exp_top[j], exp_cnt[j]);
        end
      end
      do_clear();
    end
  endtask

  task automatic test_reset_clear();
    stream.delete();
    push(5, 0, 0); push(0, 1, 0); push(6, 0, 0); push(6, 0, 0);
    drive(0);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (w_done !== 5'b0 || m0 !== 40'd0 || t0 !== 42'd0 || w_cnt[0] !== 16'd0) begin
      errors++; $display("FAIL midreset done=%b max=%0d top=%0d cnt=%0d exp all 0", w_done, m0, t0, w_cnt[0]);
    end
    @(negedge clk);
    rst_n = 1;
    stream.delete();
    push(3, 0, 0); push(4, 0, 1);
    drive(0);
    @(negedge clk);
    #1;
    checks++;
    if (w_done[0] !== 1'b1 || m0 !== 40'd7 || w_cnt[0] !== 16'd1) begin
      errors++; $display("FAIL post_reset done=%0b max=%0d cnt=%0d exp 1 7 1", w_done[0], m0, w_cnt[0]);
    end
    @(negedge clk);
    clear = 1;
    in_valid = 1;
    in_data = 99;
    in_last = 1;
    #1;
    checks++;
    if (w_rdy !== 5'b0) begin
      errors++; $display("FAIL clear_ready got %b exp 00000", w_rdy);
    end
    @(negedge clk);
    clear = 0;
    in_valid = 0;
    in_data = 0;
    in_last = 0;
    #1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w_done[j] !== 1'b0 || act_max[j] !== 0 || act_top[j] !== 0 || w_cnt[j] !== 16'd0 || w_rdy[j] !== 1'b1) begin
        errors++;
        $display("FAIL clear dut%0d done=%0b max=%0d top=%0d cnt=%0d rdy=%0b exp 0 0 0 0 1",
                 j, w_done[j], act_max[j], act_top[j], w_cnt[j], w_rdy[j]);
      end
    end
    stream.delete();
    push(7, 0, 1);
    drive(0);
    @(negedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (w_done[j] !== 1'b1 || act_max[j] !== 64'd7 || act_top[j] !== 64'd7 || w_cnt[j] !== 16'd1) begin
        errors++;
        $display("FAIL fresh7 dut%0d done=%0b max=%0d top=%0d cnt=%0d exp 1 7 7 1",
                 j, w_done[j], act_max[j], act_top[j], w_cnt[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_puzzle();
    test_back_to_back();
    test_ties();
    test_saturation();
    test_random();
    test_reset_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
